// File: rtl/inst_encoder_pkg.sv
// Shared instruction-format definitions: op codes, opcode field constants,
// request payload and encoder states, common to the encoder and the decoder.
package inst_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 3'd0,
        OP_ADDI  = 3'd1,
        OP_LD    = 3'd2,
        OP_ST    = 3'd3,
        OP_LU12I = 3'd4,
        OP_BNE   = 3'd5
    } op_e;

    localparam logic [16:0] OPC_ADD   = 17'b00000000000100000;
    localparam logic [9:0]  OPC_ADDI  = 10'b0000001010;
    localparam logic [9:0]  OPC_LD    = 10'b0010100010;
    localparam logic [9:0]  OPC_ST    = 10'b0010100110;
    localparam logic [6:0]  OPC_LU12I = 7'b0001010;
    localparam logic [5:0]  OPC_BNE   = 6'b010111;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rj;
        logic [REG_W-1:0]  rk;
        logic [INST_W-1:0] imm;
    } inst_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_DONE
    } enc_state_e;

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational field packer: request fields -> 32-bit word plus legality flag.
module inst_pack
    import inst_pkg::*;
(
    input  inst_req_t          i_req,
    output logic [INST_W-1:0]  o_word_c,
    output logic               o_legal_c
);

    logic w_imm12_ok;
    logic w_bne_ok;

    // Sign-extension checks: the dropped upper bits must all equal the kept sign bit.
    assign w_imm12_ok = (&i_req.imm[31:11]) | ~(|i_req.imm[31:11]);
    assign w_bne_ok   = ((&i_req.imm[31:17]) | ~(|i_req.imm[31:17]))
                        & (i_req.imm[1:0] == 2'b00);

    always_comb begin
        o_word_c  = '0;
        o_legal_c = 1'b0;
        case (i_req.op)
            OP_ADD: begin
                o_word_c  = {OPC_ADD, i_req.rk, i_req.rj, i_req.rd};
                o_legal_c = 1'b1;
            end
            OP_ADDI: begin
                o_word_c  = {OPC_ADDI, i_req.imm[11:0], i_req.rj, i_req.rd};
                o_legal_c = w_imm12_ok;
            end
            OP_LD: begin
                o_word_c  = {OPC_LD, i_req.imm[11:0], i_req.rj, i_req.rd};
                o_legal_c = w_imm12_ok;
            end
            OP_ST: begin
                o_word_c  = {OPC_ST, i_req.imm[11:0], i_req.rj, i_req.rd};
                o_legal_c = w_imm12_ok;
            end
            OP_LU12I: begin
                o_word_c  = {OPC_LU12I, i_req.imm[31:12], i_req.rd};
                o_legal_c = (i_req.imm[11:0] == 12'h000);
            end
            OP_BNE: begin
                o_word_c  = {OPC_BNE, i_req.imm[17:2], i_req.rj, i_req.rd};
                o_legal_c = w_bne_ok;
            end
            default: begin
                o_word_c  = '0;
                o_legal_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder / program loader: accepts field-level requests, packs them
// and writes them to consecutive instruction-memory words over an ack handshake.
module inst_encoder
    import inst_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     in_op,
    input  logic [REG_W-1:0]    in_rd,
    input  logic [REG_W-1:0]    in_rj,
    input  logic [REG_W-1:0]    in_rk,
    input  logic [INST_W-1:0]   in_imm,
    input  logic                in_last,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [INST_W-1:0]   imem_wdata,
    input  logic                imem_ack,
    output logic [ADDR_W:0]     words,
    output logic                err,
    output logic                done
);

    localparam int unsigned        WORDS_W  = ADDR_W + 1;
    localparam logic [ADDR_W-1:0]  BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [WORDS_W-1:0] CAPACITY = WORDS_W'(1) << ADDR_W;

    enc_state_e          r_state, w_state_next;
    logic                r_in_ready, r_we, r_done, r_err, r_last;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic [INST_W-1:0]   r_wdata, w_wdata_next;
    logic [WORDS_W-1:0]  r_words, w_words_next;
    logic                w_err_next, w_last_next;
    inst_req_t           w_req;
    logic [INST_W-1:0]   w_word;
    logic                w_legal;

    assign w_req = '{op: in_op, rd: in_rd, rj: in_rj, rk: in_rk, imm: in_imm};

    inst_pack u_pack (
        .i_req     (w_req),
        .o_word_c  (w_word),
        .o_legal_c (w_legal)
    );

    // Next-state and datapath update.
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_words_next = r_words;
        w_err_next   = r_err;
        w_last_next  = r_last;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_ACCEPT;
                    w_addr_next  = BASE;
                    w_words_next = '0;
                    w_err_next   = 1'b0;
                end
            end
            ST_ACCEPT: begin
                if (in_valid && r_in_ready) begin
                    // A full memory rejects even well-formed requests so addr never wraps.
                    if (w_legal && (r_words != CAPACITY)) begin
                        w_wdata_next = w_word;
                        w_last_next  = in_last;
                        w_state_next = ST_WRITE;
                    end else begin
                        w_err_next = 1'b1;
                        if (in_last) begin
                            w_state_next = ST_DONE;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (imem_ack) begin
                    w_addr_next  = r_addr + ADDR_W'(1);
                    w_words_next = r_words + WORDS_W'(1);
                    w_state_next = r_last ? ST_DONE : ST_ACCEPT;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register; handshake outputs are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_addr     <= BASE;
            r_wdata    <= '0;
            r_words    <= '0;
            r_err      <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == ST_ACCEPT);
            r_we       <= (w_state_next == ST_WRITE);
            r_done     <= (w_state_next == ST_DONE);
            r_addr     <= w_addr_next;
            r_wdata    <= w_wdata_next;
            r_words    <= w_words_next;
            r_err      <= w_err_next;
            r_last     <= w_last_next;
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign words      = r_words;
    assign err        = r_err;
    assign done       = r_done;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder (4-word memory) against a field-rule reference model.
module tb_inst_encoder;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned BASE   = 0;
    localparam int unsigned CAP    = 4;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last, imem_ack;
    logic [2:0]  in_op;
    logic [4:0]  in_rd, in_rj, in_rk;
    logic [31:0] in_imm;
    logic        in_ready, imem_we, err, done;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [ADDR_W:0] words;

    int n_cmp = 0;
    int n_bad = 0;
    int m_words = 0;
    logic m_err = 1'b0;

    inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rj(in_rj), .in_rk(in_rk), .in_imm(in_imm),
        .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ack(imem_ack),
        .words(words), .err(err), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference encoding from the instruction-format rules, using plain arithmetic.
    function automatic logic [31:0] ref_enc(input int op, input logic [31:0] rd,
                                            input logic [31:0] rj, input logic [31:0] rk,
                                            input logic [31:0] imm);
        case (op)
            0: return 32'h0010_0000 + rk * 1024 + rj * 32 + rd;
            1: return 32'h0280_0000 + (imm % 4096) * 1024 + rj * 32 + rd;
            2: return 32'h2880_0000 + (imm % 4096) * 1024 + rj * 32 + rd;
            3: return 32'h2980_0000 + (imm % 4096) * 1024 + rj * 32 + rd;
            4: return 32'h1400_0000 + (imm / 4096) * 32 + rd;
            5: return 32'h5C00_0000 + ((imm / 4) % 65536) * 1024 + rj * 32 + rd;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_legal(input int op, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (op)
            0: return 1'b1;
            1, 2, 3: return (s >= -2048) && (s <= 2047);
            4: return (imm % 4096) == 0;
            5: return ((imm % 4) == 0) && (s >= -131072) && (s <= 131071);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},   32'(in_ready),   32'd0);
        check({tag, "_we"},    32'(imem_we),    32'd0);
        check({tag, "_addr"},  32'(imem_addr),  32'(BASE));
        check({tag, "_wdata"}, imem_wdata,      32'd0);
        check({tag, "_words"}, 32'(words),      32'd0);
        check({tag, "_err"},   32'(err),        32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_words = 0;
        m_err   = 1'b0;
        check("start_rdy", 32'(in_ready), 32'd1);
        check("start_words", 32'(words), 32'd0);
        check("start_done", 32'(done), 32'd0);
    endtask

    // One request through the handshake, with ack_delay WRITE cycles before imem_ack.
    task automatic send(input int op, input int rd, input int rj, input int rk,
                        input logic [31:0] imm, input logic last, input int ack_delay);
        logic ok;
        logic [31:0] w;
        ok = ref_legal(op, imm) && (m_words < CAP);
        w  = ref_enc(op, 32'(rd), 32'(rj), 32'(rk), imm);
        check("req_rdy", 32'(in_ready), 32'd1);
        in_op = 3'(op); in_rd = 5'(rd); in_rj = 5'(rj); in_rk = 5'(rk);
        in_imm = imm; in_last = last; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (ok) begin
            check("wr_we", 32'(imem_we), 32'd1);
            check("wr_addr", 32'(imem_addr), (BASE + m_words) % CAP);
            check("wr_data", imem_wdata, w);
            check("wr_rdy", 32'(in_ready), 32'd0);
            for (int i = 0; i < ack_delay; i++) begin
                tick();
                check("hold_we", 32'(imem_we), 32'd1);
                check("hold_addr", 32'(imem_addr), (BASE + m_words) % CAP);
                check("hold_data", imem_wdata, w);
                check("hold_rdy", 32'(in_ready), 32'd0);
            end
            imem_ack = 1'b1;
            tick();
            imem_ack = 1'b0;
            m_words++;
        end else begin
            m_err = 1'b1;
        end
        check("post_we", 32'(imem_we), 32'd0);
        check("post_words", 32'(words), 32'(m_words));
        check("post_err", 32'(err), 32'(m_err));
        check("post_done", 32'(done), 32'(last));
        check("post_rdy", 32'(in_ready), 32'(!last));
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] edges [8];
        edges = '{32'h0000_07FF, 32'hFFFF_F800, 32'h0000_0800, 32'hFFFF_F7FF,
                  32'h0001_FFFC, 32'hFFFE_0000, 32'h0002_0000, 32'h8000_0000};
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 4095)) - 32'd2048;
            1: return 32'($urandom) * 32'd4096;
            2: return edges[$urandom_range(0, 7)];
            3: return (32'($urandom_range(0, 65535)) - 32'd32768) * 32'd4;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; imem_ack = 1'b0;
        in_op = '0; in_rd = '0; in_rj = '0; in_rk = '0; in_imm = '0;
        tick(); tick();
        rst = 1'b0;
        check_reset_vals("rst");
        tick();
        check("idle_rdy", 32'(in_ready), 32'd0);

        // ADD at BASE_ADDR
        do_start();
        send(0, 3, 1, 2, 32'd0, 1'b1, 0);
        check("add_word", imem_wdata, 32'h0010_0823);
        check("add_words", 32'(words), 32'd1);

        // ADDI then ST, single-cycle acks
        do_start();
        send(1, 4, 0, 0, 32'hFFFF_FFFF, 1'b0, 0);
        check("addi_word", imem_wdata, 32'h02BF_FC04);
        send(3, 6, 7, 0, 32'd8, 1'b1, 0);
        check("st_word", imem_wdata, 32'h2980_20E6);
        check("st_err", 32'(err), 32'd0);

        // LU12I / BNE legality; start in ACCEPT is ignored
        do_start();
        send(4, 5, 0, 0, 32'h1234_5000, 1'b0, 1);
        check("lu12i_word", imem_wdata, 32'h1424_68A5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_start_rdy", 32'(in_ready), 32'd1);
        check("ign_start_words", 32'(words), 32'd1);
        send(4, 5, 0, 0, 32'h1234_5001, 1'b0, 0);
        check("lu12i_drop_err", 32'(err), 32'd1);
        send(5, 2, 1, 0, 32'hFFFF_FFF8, 1'b0, 0);
        check("bne_word", imem_wdata, 32'h5FFF_F822);
        send(5, 2, 1, 0, 32'd6, 1'b0, 0);
        send(5, 2, 1, 0, 32'h0002_0000, 1'b1, 0);
        check("bne_words", 32'(words), 32'd2);

        // Stalled ack, then reset in the middle of a WRITE
        do_start();
        send(0, 1, 2, 3, 32'd0, 1'b0, 5);
        in_op = 3'd2; in_rd = 5'd9; in_rj = 5'd10; in_imm = 32'd16; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_start_we", 32'(imem_we), 32'd1);
        check("ign_start_data", imem_wdata, ref_enc(2, 32'd9, 32'd10, 32'd0, 32'd16));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("midrst");

        // Capacity: 4 writes, the fifth is dropped
        do_start();
        for (int i = 0; i < 5; i++) send(0, i, i + 1, i + 2, 32'd0, 1'(i == 4), 0);
        check("cap_words", 32'(words), 32'd4);
        check("cap_err", 32'(err), 32'd1);

        // Randomized sessions
        for (int s = 0; s < 12; s++) begin
            int n;
            do_start();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++)
                send($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), rand_imm(), 1'(i == n - 1), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Sequential instruction encoder and program loader: the write-side counterpart of the core's instruction decoder. It accepts field-level instruction requests (op, rd, rj, rk, imm) over a valid/ready handshake, range-checks and packs them into 32-bit LoongArch words for ADD.W, ADDI.W, LD.W, ST.W, LU12I.W and BNE, and writes them to consecutive instruction-memory addresses through an ack-handshaked write port. It sits between the test/boot controller and the instruction RAM, ahead of the decoder.

## Interface
- ADDR_W, 10, word-address width of instruction memory
- BASE_ADDR, 0, first word address written after `start`
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load session; honoured only in IDLE or DONE
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_op  in  3  0 ADD, 1 ADDI, 2 LD, 3 ST, 4 LU12I, 5 BNE, 6/7 illegal
- in_rd, in_rj, in_rk  in  5 each  register fields (ST: in_rd is store-data source; BNE: in_rd is second compare register)
- in_imm  in  32  full signed value (LU12I: 32-bit value to load; BNE: byte offset)
- in_last  in  1  final request of the session
- imem_we  out  1  write request
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded word
- imem_ack  in  1  memory accepted the write this cycle
- words  out  ADDR_W+1  words written this session
- err  out  1  sticky: at least one request dropped
- done  out  1  session complete

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: in_ready=0. `start` → ACCEPT; addr←BASE_ADDR, words←0, err←0.
- ACCEPT: in_ready=1. On in_valid&in_ready: encode and validate.
  - Valid → latch word, → WRITE.
  - Invalid → drop, err←1; → DONE if in_last, else stay ACCEPT.
- WRITE: imem_we=1, addr/wdata held. On imem_ack: addr+1, words+1; → DONE if latched last, else ACCEPT.
- DONE: done=1, in_ready=0; `start` starts a new session as from IDLE.
- Encoding (rd→[4:0], rj→[9:5], rk→[14:10]):
  - ADD: [31:15]=17'b00000000000100000.
  - ADDI/LD/ST: [31:22]=10'b0000001010 / 10'b0010100010 / 10'b0010100110; [21:10]=imm[11:0].
  - LU12I: [31:25]=7'b0001010; [24:5]=imm[31:12].
  - BNE: [31:26]=6'b010111; [25:10]=imm[17:2].
- Validation (reject on failure):
  - op 6/7 illegal.
  - ADDI/LD/ST: imm[31:11] all equal.
  - LU12I: imm[11:0]==0.
  - BNE: imm[1:0]==0 and imm[31:17] all equal.
- Capacity: once words reaches 2^ADDR_W, further requests are dropped with err←1; addr never wraps into already-written words.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, words 0, err 0, done 0. Reset overrides everything, including mid-WRITE (imem_we drops next cycle).
- Accept at cycle k → imem_we=1 from k+1, stable until ack sampled; ack in the first WRITE cycle gives 1 word per 2 cycles.
- in_ready is a registered state decode, independent of in_valid.
- `start` in ACCEPT/WRITE ignored. in_last on a dropped request still ends the session.
- words/err update in the cycle after the triggering edge; done asserts the cycle after the final ack or drop.

## Structure
- Package inst_pkg: op enum (OP_ADD…OP_BNE), opcode field constants, shared with the decoder.
- Sub-module inst_pack: combinational fields→{word, legal}; FSM, counters and handshake in inst_encoder.

## Test plan
- ADD rd=3 rj=1 rk=2 → imem_wdata 0x00100823 at BASE_ADDR; words=1.
- ADDI rd=4 rj=0 imm=-1, then ST rd=6 rj=7 imm=8 (in_last) → 0x02BFFC04, 0x298020E6 at addresses 0,1; done=1, err=0.
- LU12I rd=5 imm=0x12345000 → 0x142468A5; LU12I imm=0x12345001 → dropped, err=1, words unchanged.
- BNE rj=1 rd=2 imm=-8 → 0x5FFFF822; imm=6 or 0x20000 → dropped, err=1.
- imem_ack held low 5 cycles → imem_we, addr, wdata stable, in_ready=0; rst in cycle 3 → all outputs at reset values next cycle.
- ADDR_W=2: five valid requests → four written, fifth dropped, err=1, words=4.
